register_pipeline: RTL and testbench
====================================

# register_pipeline

Parametrised multi-stage successor to the single-stage register bank: a DEPTH-deep chain of WIDTH-bit registers sharing one set of secondary controls (ena, sclr, sload, aclr), with a per-stage valid bit, an occupancy counter and a selectable tap. It sits wherever a datapath needs a stallable, flushable fixed-latency delay line with bubble tracking, such as retiming a stream alongside a multi-cycle arithmetic unit.

## Interface
- WIDTH, 16, data width in bits (≥1)
- DEPTH, 4, number of stages (1..32)
- TAPW, derived, clog2(DEPTH) with minimum 1; width of tap_sel
- CNTW, derived, clog2(DEPTH+1); width of count
- clk  in  1  clock, all state updates on rising edge
- aclr  in  1  reset, asynchronous, active-high
- ena  in  1  clock enable; gates every synchronous update including sclr
- sclr  in  1  synchronous clear/flush of all stages
- sload  in  1  load sdata instead of d into stage 0
- d  in  WIDTH  normal input data
- d_valid  in  1  d carries a valid item
- sdata  in  WIDTH  alternate load data, always treated as valid
- tap_sel  in  TAPW  stage index for tap outputs
- q  out  WIDTH  stage DEPTH-1 data
- q_valid  out  1  stage DEPTH-1 valid
- tap_q  out  WIDTH  data of stage tap_sel
- tap_valid  out  1  valid of stage tap_sel
- count  out  CNTW  number of valid stages
- empty  out  1  count == 0
- full  out  1  count == DEPTH

## Operation
- State: data[0..DEPTH-1], valid[0..DEPTH-1], count register.
- aclr=1: all data, valid and count go to 0 immediately, independent of clk; empty=1, full=0.
- Rising edge with ena=0: all state holds; sclr, sload, d_valid ignored.
- Rising edge with ena=1, priority sclr > sload > d:
  - sclr=1: all data←0, all valid←0, count←0.
  - else stage 0: data←sload ? sdata : d; valid←sload | d_valid. Stage k≥1: data[k]←data[k-1], valid[k]←valid[k-1].
  - Data advances even when invalid; invalid stages are bubbles and are not compacted.
- count update on enabled non-clear edge: count←count + in_v − valid[DEPTH-1], where in_v = sload | d_valid. Both terms 1 leaves count unchanged. count must equal popcount(valid) at all times; never exceeds DEPTH and never underflows.
- Tap: tap_q/tap_valid are a combinational mux of registered stage state. tap_sel ≥ DEPTH forces tap_q=0, tap_valid=0.
- DEPTH=1: q is data[0]; tap_sel is 1 bit, and value 1 is out of range.

## Timing
- Latency: an item accepted on enabled edge n appears on q/q_valid after enabled edge n+DEPTH-1, i.e. it is present once DEPTH enabled edges have occurred. Disabled cycles add no latency count.
- Throughput: one item per enabled cycle.
- q, q_valid, count, empty and full are register outputs or decodes of registers and change only on enabled edges or on aclr.
- tap outputs respond to tap_sel in the same cycle, with no added latency.
- aclr deassertion is synchronous to the system. The first update is the first enabled edge after release.
- Reset mid-stream: aclr discards all items, and no partial state survives.

## Test plan
- Reset: hold aclr for 3 cycles with random inputs. Expect q=0, q_valid=0, count=0, empty=1, full=0. Release aclr with ena=0: still 0.
- Latency/fill (WIDTH=16, DEPTH=4): ena=1, d_valid=1, d=0x0001..0x0006 on consecutive cycles. Expect q=0x0001 with q_valid=1 after the 4th edge. count reads 1,2,3,4,4,4, and full=1 from the 4th edge.
- Stall and bubbles: push 0xAAAA, then a bubble (d_valid=0), then 0xBBBB. Insert 2 cycles of ena=0 with sclr=1 and d changing. Expect state frozen and count=2. Resuming gives q sequence 0xAAAA(valid), bubble(invalid), 0xBBBB(valid).
- Priority: with ena=1, sclr=1 and sload=1 together, expect all cleared and count=0. Next, sload=1 with sdata=0x1234, d=0x5678, d_valid=0: stage 0 gets 0x1234 valid and count=1.
- Drain: with the pipe full, hold d_valid=0 for 4 enabled edges. count goes 3,2,1,0, empty=1 at the end, and there is never an underflow.
- Tap: with stages holding 0x0004,0x0003,0x0002,0x0001 (stage 0..3), sweep tap_sel 0..3. Expect a matching tap_q with tap_valid=1 in the same cycle. With DEPTH=3 and tap_sel=3, expect tap_q=0 and tap_valid=0.

Source files
------------

// File: rtl/register_pipeline_if.sv
// Bus bundle for register_pipeline: secondary controls, input data, tap select and pipe status.
interface register_pipeline_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned TAPW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNTW = $clog2(DEPTH + 1);

  logic             ena;
  logic             sclr;
  logic             sload;
  logic [WIDTH-1:0] d;
  logic             d_valid;
  logic [WIDTH-1:0] sdata;
  logic [TAPW-1:0]  tap_sel;
  logic [WIDTH-1:0] q;
  logic             q_valid;
  logic [WIDTH-1:0] tap_q;
  logic             tap_valid;
  logic [CNTW-1:0]  count;
  logic             empty;
  logic             full;

  modport master (
    output ena, sclr, sload, d, d_valid, sdata, tap_sel,
    input  q, q_valid, tap_q, tap_valid, count, empty, full
  );

  modport slave (
    input  ena, sclr, sload, d, d_valid, sdata, tap_sel,
    output q, q_valid, tap_q, tap_valid, count, empty, full
  );
endinterface

// File: rtl/register_pipeline.sv
// Stallable, flushable DEPTH-stage delay line with per-stage valid bits,
// occupancy tracking and a combinational tap onto any stage.
module register_pipeline #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input logic                clk,
  input logic                aclr,
  register_pipeline_if.slave bus
);
  localparam int unsigned TAPW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNTW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [CNTW-1:0]  count_q;
  logic             empty_q;
  logic             full_q;

  logic             in_v;
  logic [CNTW-1:0]  count_nxt;
  logic [WIDTH-1:0] tap_q_c;
  logic             tap_valid_c;

  // Entering and leaving items cancel; full implies the last stage is valid, so no overflow.
  always_comb begin
    in_v      = bus.sload | bus.d_valid;
    count_nxt = count_q + CNTW'(in_v) - CNTW'(valid_q[DEPTH-1]);
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      for (int unsigned k = 0; k < DEPTH; k++) data_q[k] <= '0;
      valid_q <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else if (bus.ena) begin
      if (bus.sclr) begin
        for (int unsigned k = 0; k < DEPTH; k++) data_q[k] <= '0;
        valid_q <= '0;
        count_q <= '0;
        empty_q <= 1'b1;
        full_q  <= 1'b0;
      end else begin
        // Bubbles advance with the data; nothing is compacted.
        data_q[0]  <= bus.sload ? bus.sdata : bus.d;
        valid_q[0] <= in_v;
        for (int unsigned k = 1; k < DEPTH; k++) begin
          data_q[k]  <= data_q[k-1];
          valid_q[k] <= valid_q[k-1];
        end
        count_q <= count_nxt;
        empty_q <= (count_nxt == '0);
        full_q  <= (count_nxt == CNTW'(DEPTH));
      end
    end
  end

  // Out-of-range selects match no stage and fall through to zero.
  always_comb begin
    tap_q_c     = '0;
    tap_valid_c = 1'b0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (bus.tap_sel == TAPW'(k)) begin
        tap_q_c     = data_q[k];
        tap_valid_c = valid_q[k];
      end
    end
  end

  assign bus.q         = data_q[DEPTH-1];
  assign bus.q_valid   = valid_q[DEPTH-1];
  assign bus.tap_q     = tap_q_c;
  assign bus.tap_valid = tap_valid_c;
  assign bus.count     = count_q;
  assign bus.empty     = empty_q;
  assign bus.full      = full_q;
endmodule

// File: tb/tb_register_pipeline.sv
// Directed bench for register_pipeline: a DEPTH=4 unit for the main sequence and
// a DEPTH=3 unit for the out-of-range tap case.
module tb_register_pipeline;
  logic clk;
  logic aclr;
  int   checks;
  int   errors;

  register_pipeline_if #(.WIDTH(16), .DEPTH(4)) bus ();
  register_pipeline_if #(.WIDTH(16), .DEPTH(3)) bus3 ();

  register_pipeline #(.WIDTH(16), .DEPTH(4)) dut (
    .clk (clk),
    .aclr(aclr),
    .bus (bus)
  );

  register_pipeline #(.WIDTH(16), .DEPTH(3)) dut3 (
    .clk (clk),
    .aclr(aclr),
    .bus (bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic check_status(input string tag, input logic [15:0] eq, input logic eqv,
                              input int ecount, input logic eempty, input logic efull);
    check({tag, ".q"},       32'(bus.q), 32'(eq));
    check({tag, ".q_valid"}, 32'(bus.q_valid), 32'(eqv));
    check({tag, ".count"},   32'(bus.count), 32'(ecount));
    check({tag, ".empty"},   32'(bus.empty), 32'(eempty));
    check({tag, ".full"},    32'(bus.full), 32'(efull));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    bus.ena = 1'b0; bus.sclr = 1'b0; bus.sload = 1'b0; bus.d = '0;
    bus.d_valid = 1'b0; bus.sdata = '0; bus.tap_sel = '0;
    bus3.ena = 1'b0; bus3.sclr = 1'b0; bus3.sload = 1'b0; bus3.d = '0;
    bus3.d_valid = 1'b0; bus3.sdata = '0; bus3.tap_sel = '0;

    // Reset held for three cycles with random stimulus
    aclr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.ena = 1'b1; bus.sclr = 1'($urandom); bus.sload = 1'($urandom);
      bus.d = 16'($urandom); bus.d_valid = 1'($urandom); bus.sdata = 16'($urandom);
      step();
    end
    check_status("reset", 16'h0000, 1'b0, 0, 1'b1, 1'b0);

    aclr = 1'b0;
    bus.ena = 1'b0; bus.d_valid = 1'b1; bus.sload = 1'b1;
    step();
    check_status("release_disabled", 16'h0000, 1'b0, 0, 1'b1, 1'b0);

    // Fill with 1..6; tap sweep once stages hold 4,3,2,1
    bus.ena = 1'b1; bus.sclr = 1'b0; bus.sload = 1'b0; bus.d_valid = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      bus.d = 16'(i);
      step();
      check_status($sformatf("fill%0d", i), (i >= 4) ? 16'(i - 3) : 16'h0000,
                   (i >= 4), (i >= 4) ? 4 : i, 1'b0, (i >= 4));
      if (i == 4) begin
        for (int t = 0; t < 4; t++) begin
          bus.tap_sel = 2'(t);
          #1;
          check($sformatf("tap%0d.q", t), 32'(bus.tap_q), 32'(4 - t));
          check($sformatf("tap%0d.valid", t), 32'(bus.tap_valid), 32'd1);
        end
      end
    end

    // Drain: stages hold 6,5,4,3
    bus.d_valid = 1'b0; bus.d = 16'h0000;
    step(); check_status("drain1", 16'h0004, 1'b1, 3, 1'b0, 1'b0);
    step(); check_status("drain2", 16'h0005, 1'b1, 2, 1'b0, 1'b0);
    step(); check_status("drain3", 16'h0006, 1'b1, 1, 1'b0, 1'b0);
    step(); check_status("drain4", 16'h0000, 1'b0, 0, 1'b1, 1'b0);
    step(); check_status("drain_extra", 16'h0000, 1'b0, 0, 1'b1, 1'b0);

    // Item, bubble, item
    bus.d = 16'hAAAA; bus.d_valid = 1'b1; step();
    bus.d = 16'h1111; bus.d_valid = 1'b0; step();
    bus.d = 16'hBBBB; bus.d_valid = 1'b1; step();
    check_status("bubbles_loaded", 16'h0000, 1'b0, 2, 1'b0, 1'b0);

    // Stall with sclr asserted must be ignored
    bus.ena = 1'b0; bus.sclr = 1'b1; bus.tap_sel = 2'd2;
    for (int i = 0; i < 2; i++) begin
      bus.d = 16'(16'hC000 + i);
      step();
      check_status($sformatf("stall%0d", i), 16'h0000, 1'b0, 2, 1'b0, 1'b0);
      check($sformatf("stall%0d.tap_q", i), 32'(bus.tap_q), 32'hAAAA);
      check($sformatf("stall%0d.tap_valid", i), 32'(bus.tap_valid), 32'd1);
    end

    bus.ena = 1'b1; bus.sclr = 1'b0; bus.d_valid = 1'b0; bus.d = 16'h0000;
    step(); check_status("resume1", 16'hAAAA, 1'b1, 2, 1'b0, 1'b0);
    step(); check_status("resume2", 16'h1111, 1'b0, 1, 1'b0, 1'b0);
    step(); check_status("resume3", 16'hBBBB, 1'b1, 1, 1'b0, 1'b0);
    step(); check_status("resume4", 16'h0000, 1'b0, 0, 1'b1, 1'b0);

    // Priority: sclr beats sload
    bus.d = 16'h7777; bus.d_valid = 1'b1; step();
    check("prio_pre.count", 32'(bus.count), 32'd1);
    bus.sclr = 1'b1; bus.sload = 1'b1; bus.sdata = 16'h9999; bus.tap_sel = 2'd0;
    step();
    check_status("prio_clear", 16'h0000, 1'b0, 0, 1'b1, 1'b0);
    check("prio_clear.tap_q", 32'(bus.tap_q), 32'h0000);
    check("prio_clear.tap_valid", 32'(bus.tap_valid), 32'd0);

    bus.sclr = 1'b0; bus.sload = 1'b1; bus.sdata = 16'h1234; bus.d = 16'h5678; bus.d_valid = 1'b0;
    step();
    check("sload.tap_q", 32'(bus.tap_q), 32'h1234);
    check("sload.tap_valid", 32'(bus.tap_valid), 32'd1);
    check("sload.count", 32'(bus.count), 32'd1);
    check("sload.empty", 32'(bus.empty), 32'd0);

    // Asynchronous reset mid-cycle discards the item
    bus.sload = 1'b0; bus.d_valid = 1'b1; bus.d = 16'h4242;
    #2;
    aclr = 1'b1;
    #1;
    check("async.count", 32'(bus.count), 32'd0);
    check("async.empty", 32'(bus.empty), 32'd1);
    check("async.tap_valid", 32'(bus.tap_valid), 32'd0);
    check("async.tap_q", 32'(bus.tap_q), 32'h0000);
    step();
    aclr = 1'b0;
    bus.ena = 1'b0;

    // DEPTH=3: select 3 is out of range
    bus3.ena = 1'b1; bus3.d_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus3.d = 16'(16'h0009 - i);
      step();
    end
    bus3.ena = 1'b0;
    bus3.tap_sel = 2'd3;
    #1;
    check("d3_tap3.q", 32'(bus3.tap_q), 32'h0000);
    check("d3_tap3.valid", 32'(bus3.tap_valid), 32'd0);
    bus3.tap_sel = 2'd2;
    #1;
    check("d3_tap2.q", 32'(bus3.tap_q), 32'h0009);
    check("d3_tap2.valid", 32'(bus3.tap_valid), 32'd1);
    check("d3.full", 32'(bus3.full), 32'd1);
    check("d3.count", 32'(bus3.count), 32'd3);
    check("d3.q", 32'(bus3.q), 32'h0009);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
